cic_interpolator: RTL and testbench

//  Cascaded Integrator-Comb interpolator: the upsampling counterpart of cic_decimator, used in the MSO signal-generator/DAC path.
//  M comb stages run at the low (input) rate; a zero-stuffer raises the rate by R; M integrators run at full clk rate.

---
 rtl/cic_interpolator.sv | 105 ++++++++++
 tb/tb_cic_interpolator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// Cascaded integrator-comb interpolator: low-rate comb chain, zero-stuff by R, full-rate integrators.
// Optional output clamping: define CIC_INTERPOLATOR_SATURATE_EN (default wraps by MSB truncation).
module cic_interpolator #(
  parameter int unsigned R         = 2,
  parameter int unsigned N         = 1,
  parameter int unsigned M         = 2,
  parameter int unsigned X_WIDTH   = 12,
  parameter int unsigned Y_WIDTH   = X_WIDTH,
  parameter int unsigned PRECISION = X_WIDTH + M * $clog2(R * N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enabled,
  input  logic signed [X_WIDTH-1:0]  x,
  output logic                       x_req,
  output logic signed [Y_WIDTH-1:0]  y,
  output logic                       y_valid
);

  localparam int unsigned GAIN_SHIFT = M * $clog2(R * N) - $clog2(R);
  localparam int unsigned PW         = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned VW         = (Y_WIDTH > PRECISION) ? Y_WIDTH : PRECISION;
  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

  logic [PW-1:0]               phase_q;
  logic                        phase_zero;
  logic signed [PRECISION-1:0] dly_q [M][N];
  logic signed [PRECISION-1:0] comb_in [M];
  logic signed [PRECISION-1:0] comb_out;
  logic signed [PRECISION-1:0] u_q;
  logic                        u_stb_q;
  logic signed [PRECISION-1:0] s_q [M];
  logic signed [PRECISION-1:0] shifted;
  logic signed [VW-1:0]        v;
  logic signed [Y_WIDTH-1:0]   y_d;

  assign phase_zero = (phase_q == '0);
  assign x_req      = enabled & phase_zero & rst_n;

  // Comb chain evaluated on the current input; stage k sees the output of stage k-1.
  always_comb begin
    logic signed [PRECISION-1:0] acc;
    acc = PRECISION'(x);
    for (int k = 0; k < M; k++) begin
      comb_in[k] = acc;
      acc        = acc - dly_q[k][N-1];
    end
    comb_out = acc;
  end

  always_comb begin
    shifted = s_q[M-1] >>> GAIN_SHIFT;
    v       = VW'(shifted);
`ifdef CIC_INTERPOLATOR_SATURATE_EN
    begin
      logic signed [VW-1:0] y_max;
      logic signed [VW-1:0] y_min;
      y_max = {{(VW - Y_WIDTH + 1){1'b0}}, {(Y_WIDTH - 1){1'b1}}};
      y_min = ~y_max;
      if (v > y_max)      y_d = y_max[Y_WIDTH-1:0];
      else if (v < y_min) y_d = y_min[Y_WIDTH-1:0];
      else                y_d = v[Y_WIDTH-1:0];
    end
`else
    y_d = v[Y_WIDTH-1:0];
`endif
  end

  if (VW > Y_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^v[VW-1:Y_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      u_q     <= '0;
      u_stb_q <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      for (int k = 0; k < M; k++) begin
        s_q[k] <= '0;
        for (int j = 0; j < N; j++) dly_q[k][j] <= '0;
      end
    end else begin
      y_valid <= enabled;
      if (enabled) begin
        phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        u_stb_q <= phase_zero;
        if (phase_zero) begin
          u_q <= comb_out;
          for (int k = 0; k < M; k++) begin
            dly_q[k][0] <= comb_in[k];
            for (int j = 1; j < N; j++) dly_q[k][j] <= dly_q[k][j-1];
          end
        end
        // Zero-stuffing: only the cycle after a sample feeds a non-zero value.
        s_q[0] <= s_q[0] + (u_stb_q ? u_q : '0);
        for (int k = 1; k < M; k++) s_q[k] <= s_q[k] + s_q[k-1];
        y <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: four configurations checked every cycle against a convolution model
// (upsampled input convolved with the CIC boxcar^M impulse response), plus directed literal checks.
`timescale 1ns/1ps
module tb_cic_interpolator;

  localparam int ND   = 4;
  localparam int MAXK = 16384;
  localparam int HMAX = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic signed [11:0] x0, x1, x2, x3;
  logic xr0, xr1, xr2, xr3;
  logic yv0, yv1, yv2, yv3;
  logic signed [11:0] y0, y1, y3;
  logic signed [7:0]  y2;

  always #5 clk = ~clk;

  // A: R2 N1 M2, B: R4 N1 M2, C: R2 N1 M2 with 8-bit output, D: R4 N2 M3
  cic_interpolator #(.R(2), .N(1), .M(2), .X_WIDTH(12), .Y_WIDTH(12)) u_a (
    .clk(clk), .rst_n(rst_n), .enabled(en), .x(x0), .x_req(xr0), .y(y0), .y_valid(yv0));
  cic_interpolator #(.R(4), .N(1), .M(2), .X_WIDTH(12), .Y_WIDTH(12)) u_b (
    .clk(clk), .rst_n(rst_n), .enabled(en), .x(x1), .x_req(xr1), .y(y1), .y_valid(yv1));
  cic_interpolator #(.R(2), .N(1), .M(2), .X_WIDTH(12), .Y_WIDTH(8)) u_c (
    .clk(clk), .rst_n(rst_n), .enabled(en), .x(x2), .x_req(xr2), .y(y2), .y_valid(yv2));
  cic_interpolator #(.R(4), .N(2), .M(3), .X_WIDTH(12), .Y_WIDTH(12)) u_d (
    .clk(clk), .rst_n(rst_n), .enabled(en), .x(x3), .x_req(xr3), .y(y3), .y_valid(yv3));

  int checks = 0;
  int errors = 0;

  int     w [ND][MAXK];
  longint h [ND][HMAX];
  int     hl [ND];
  int     k [ND];
  bit     yv_exp [ND];

  function automatic int cfg_r(int d); return (d == 1 || d == 3) ? 4 : 2; endfunction
  function automatic int cfg_n(int d); return (d == 3) ? 2 : 1; endfunction
  function automatic int cfg_m(int d); return (d == 3) ? 3 : 2; endfunction
  function automatic int cfg_y(int d); return (d == 2) ? 8 : 12; endfunction

  function automatic int clog2i(int val);
    int r;
    r = 0;
    while ((1 << r) < val) r++;
    return r;
  endfunction

  function automatic longint xv(int d);
    case (d)
      0:       return longint'(x0);
      1:       return longint'(x1);
      2:       return longint'(x2);
      default: return longint'(x3);
    endcase
  endfunction

  function automatic logic signed [63:0] ya(int d);
    logic signed [63:0] r;
    case (d)
      0:       r = y0;
      1:       r = y1;
      2:       r = y2;
      default: r = y3;
    endcase
    return r;
  endfunction

  function automatic logic yva(int d);
    case (d)
      0:       return yv0;
      1:       return yv1;
      2:       return yv2;
      default: return yv3;
    endcase
  endfunction

  function automatic logic xra(int d);
    case (d)
      0:       return xr0;
      1:       return xr1;
      2:       return xr2;
      default: return xr3;
    endcase
  endfunction

  // Output after enabled edge e = (h * upsampled x)[e-M-1], wrapped, scaled, narrowed.
  function automatic longint exp_y(int d);
    longint acc, v, lim, mask;
    int e, idx, m, p, g, lg;
    if (k[d] == 0) return 0;
    e   = k[d] - 1;
    m   = cfg_m(d);
    acc = 0;
    for (int i = 0; i < hl[d]; i++) begin
      idx = e - m - 1 - i;
      if (idx >= 0 && idx < MAXK) acc += h[d][i] * longint'(w[d][idx]);
    end
    lg   = clog2i(cfg_r(d) * cfg_n(d));
    p    = 12 + m * lg;
    g    = m * lg - clog2i(cfg_r(d));
    mask = (longint'(1) <<< p) - 1;
    acc  = acc & mask;
    if (acc >= (longint'(1) <<< (p - 1))) acc -= (longint'(1) <<< p);
    v   = acc >>> g;
    lim = longint'(1) <<< (cfg_y(d) - 1);
`ifdef CIC_INTERPOLATOR_SATURATE_EN
    if (v > lim - 1) v = lim - 1;
    else if (v < -lim) v = -lim;
`else
    v = v & ((lim <<< 1) - 1);
    if (v >= lim) v -= (lim <<< 1);
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: record the zero-stuffed input sequence, indexed by enabled edges since reset.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        k[d]      <= 0;
        yv_exp[d] <= 1'b0;
      end else begin
        yv_exp[d] <= en;
        if (en) begin
          if (k[d] < MAXK) w[d][k[d]] <= (k[d] % cfg_r(d) == 0) ? int'(xv(d)) : 0;
          k[d] <= k[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      logic signed [63:0] ey;
      logic eyv, exr;
      if (!rst_n) begin
        ey = 0; eyv = 1'b0; exr = 1'b0;
      end else begin
        ey  = exp_y(d);
        eyv = yv_exp[d];
        exr = en && (k[d] % cfg_r(d) == 0);
      end
      check($sformatf("model_y[%0d]", d), ya(d), ey);
      check($sformatf("model_y_valid[%0d]", d), {63'd0, yva(d)}, {63'd0, eyv});
      check($sformatf("model_x_req[%0d]", d), {63'd0, xra(d)}, {63'd0, exr});
    end
  end

  initial begin
    x3 = '0;
    forever begin
      @(posedge clk);
      #1;
      x3 = 12'($urandom);
    end
  end

  initial begin
    int imp_exp [4];
    longint t [HMAX];
    longint hsum;
    int n;
    logic signed [11:0] yh;

    imp_exp = '{1, 2, 1, 0};
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < HMAX; i++) h[d][i] = 0;
      h[d][0] = 1;
      hl[d]   = 1;
      for (int s = 0; s < cfg_m(d); s++) begin
        for (int i = 0; i < HMAX; i++) t[i] = 0;
        for (int i = 0; i < hl[d]; i++)
          for (int j = 0; j < cfg_r(d) * cfg_n(d); j++) t[i + j] += h[d][i];
        hl[d] += cfg_r(d) * cfg_n(d) - 1;
        for (int i = 0; i < HMAX; i++) h[d][i] = t[i];
      end
    end
    hsum = 0;
    for (int i = 0; i < hl[3]; i++) hsum += h[3][i];

    rst_n = 1'b0; en = 1'b0; x0 = '0; x1 = '0; x2 = '0;

    // Pin the model: R2 M2 response is 1,2,1; R4 N2 M3 has DC sum 8^3.
    check("model_hlen_a", hl[0], 3);
    check("model_hmid_a", h[0][1], 2);
    check("model_hsum_d", hsum, 512);

    step(3);
    check("reset_y", y0, 0);
    check("reset_y_valid", {63'd0, yv0}, 0);
    check("reset_x_req", {63'd0, xr0}, 0);

    // Impulse on A
    rst_n = 1'b1; en = 1'b1; x0 = 12'sd2; x1 = 12'sd300; x2 = 12'sd1000;
    step(1);
    x0 = '0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("impulse_y[%0d]", i), y0, imp_exp[i]);
      check("impulse_y_valid", {63'd0, yv0}, 1);
    end

    // DC on A; width reduction on C
    x0 = 12'sd100;
    step(9);
    for (int i = 0; i < 3; i++) begin
      check("dc100_y", y0, 100);
      step(1);
    end
`ifdef CIC_INTERPOLATOR_SATURATE_EN
    check("width_sat_y", y2, 127);
`else
    check("width_wrap_y", y2, -24);
`endif
    x0 = -12'sd2048;
    step(9);
    check("dc_neg_full_scale_y", y0, -2048);
    step(1);
    check("dc_neg_full_scale_y", y0, -2048);

    // Cadence on B: one request per four enabled clocks, freeze while disabled
    check("b_dc300_y", y1, 300);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n += int'(xr1);
    end
    check("cadence_before", n, 2);
    en = 1'b0;
    yh = y1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("frozen_x_req", {63'd0, xr1}, 0);
      check("frozen_y_valid", {63'd0, yv1}, 0);
      check("frozen_y", y1, yh);
    end
    en = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      n += int'(xr1);
    end
    check("cadence_after", n, 2);

    // Reset mid-stream with DC 500 on A
    x0 = 12'sd500;
    step(10);
    check("dc500_y", y0, 500);
    rst_n = 1'b0;
    #1;
    check("midreset_y", y0, 0);
    check("midreset_y_valid", {63'd0, yv0}, 0);
    check("midreset_x_req", {63'd0, xr0}, 0);
    step(1);
    rst_n = 1'b1;
    #1;
    check("release_x_req", {63'd0, xr0}, 1);

    // Long random run with sporadic enable drops
    for (int i = 0; i < 11600; i++) begin
      step(1);
      en = ($urandom_range(0, 7) != 0);
      x0 = 12'($urandom);
      x1 = 12'($urandom);
      x2 = 12'($urandom);
    end
    en = 1'b1;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
